gate_checker: RTL and testbench

Self-checking stimulus driver for the team's two-input and single-input primitive gates (AND, OR, XOR, NOT, XNOR). It drives a gate's inputs, samples the gate's output and checks it against the truth table of the selected gate type. It walks all four input vectors, then reports pass/fail and a per-vector error map. It sits alongside the gate modules as the on-chip or bench-side exerciser: the initiator end of the gate's a/b -> y interface.

---
 rtl/gate_chk_pkg.sv | 24 ++
 rtl/gate_ref_model.sv | 27 ++
 rtl/gate_checker.sv | 142 ++++++++++++++
 tb/tb_gate_checker.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate checker: gate select codes, FSM states,
// vector count and a select-validity helper.
package gate_chk_pkg;

  localparam logic [2:0] GSEL_AND  = 3'd0;
  localparam logic [2:0] GSEL_OR   = 3'd1;
  localparam logic [2:0] GSEL_XOR  = 3'd2;
  localparam logic [2:0] GSEL_NOT  = 3'd3;
  localparam logic [2:0] GSEL_XNOR = 3'd4;

  localparam int NUM_VECTORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 5..7 are reserved and are reported as a failed run.
  function automatic logic gsel_valid(input logic [2:0] sel);
    return (sel <= GSEL_XNOR);
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Golden truth-table model: expected gate output for a given select and inputs.
// Reserved selects produce 0.
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] gate_sel,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  // Truth table lookup; NOT ignores b.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the output
    // and no latch is inferred.
    expected = 1'b0;
    case (gate_sel)
      GSEL_AND:  expected = a & b;
      GSEL_OR:   expected = a | b;
      GSEL_XOR:  expected = a ^ b;
      GSEL_NOT:  expected = ~a;
      GSEL_XNOR: expected = ~(a ^ b);
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_checker.sv
// Gate exerciser: walks the four a/b input vectors, waits SETTLE_CYCLES
// after each, samples y_in and compares it against the reference model.
// Reports pass, a mismatch count and a per-vector error map.
module gate_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] err_vec
);

  localparam int               VW          = $clog2(NUM_VECTORS);
  localparam logic [VW-1:0]    LAST_IDX    = VW'(NUM_VECTORS - 1);
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
      $error("gate_checker: SETTLE_CYCLES must be in 1..15");
    end
  endgenerate

  state_t        state, state_next;
  logic [3:0]    settle_cnt;
  logic [VW-1:0] vec_idx;
  logic [VW-1:0] next_idx;
  logic [2:0]    gsel_q;
  logic          expected;
  logic          mismatch;
  logic          accept;
  logic          reject;
  logic          sample;
  logic          last_vec;

  gate_ref_model u_ref (
    .gate_sel (gsel_q),
    .a        (a_out),
    .b        (b_out),
    .expected (expected)
  );

  assign mismatch = (y_in != expected);
  assign last_vec = (vec_idx == LAST_IDX);
  assign next_idx = vec_idx + VW'(1);
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    sample     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (gsel_valid(gate_sel)) begin
            accept     = 1'b1;
            state_next = ST_RUN;
          end else begin
            reject     = 1'b1;
            state_next = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (settle_cnt == 4'd0) begin
          sample = 1'b1;
          if (last_vec) state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Vector drive, settle timing and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      err_vec    <= 4'd0;
      settle_cnt <= 4'd0;
      vec_idx    <= '0;
      gsel_q     <= GSEL_AND;
    end else if (accept) begin
      gsel_q     <= gate_sel;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      err_vec    <= 4'd0;
      vec_idx    <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      settle_cnt <= SETTLE_LOAD;
    end else if (reject) begin
      gsel_q    <= gate_sel;
      pass      <= 1'b0;
      err_count <= 3'd4;
      err_vec   <= 4'b1111;
    end else if (state == ST_RUN) begin
      if (sample) begin
        if (mismatch) begin
          err_vec[vec_idx] <= 1'b1;
          err_count        <= err_count + 3'd1;
        end
        if (last_vec) begin
          a_out <= 1'b0;
          b_out <= 1'b0;
          pass  <= (err_count == 3'd0) && !mismatch;
        end else begin
          vec_idx    <= next_idx;
          a_out      <= next_idx[1];
          b_out      <= next_idx[0];
          settle_cnt <= SETTLE_LOAD;
        end
      end else begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: table of runs against modelled gates, expected
// results queued at start and compared when done pulses, plus hand-written
// sequences for ignored starts, held results and mid-run reset.
module tb_gate_checker;
  import gate_chk_pkg::*;

  localparam int S = 2;

  typedef enum logic [2:0] {G_AND, G_OR, G_NOT, G_ST0, G_ST1} gate_t;

  typedef struct packed {
    logic       pass;
    logic [2:0] cnt;
    logic [3:0] vec;
  } result_t;

  typedef struct {
    string      name;
    logic [2:0] gsel;
    gate_t      gate;
    result_t    exp;
  } run_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [2:0] gate_sel = 3'd0;
  logic       y_in;
  logic       a_out, b_out, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] err_vec;
  gate_t      gate = G_AND;

  result_t sb[$];
  run_t    tbl[7];
  int      errors = 0;
  int      checks = 0;

  gate_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .gate_sel  (gate_sel),
    .a_out     (a_out),
    .b_out     (b_out),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .err_vec   (err_vec)
  );

  always #5 clk = ~clk;

  // Gate under test, modelled independently of the RTL reference.
  always_comb begin
    y_in = 1'b0;
    case (gate)
      G_AND:   y_in = a_out & b_out;
      G_OR:    y_in = a_out | b_out;
      G_NOT:   y_in = ~a_out;
      G_ST0:   y_in = 1'b0;
      G_ST1:   y_in = 1'b1;
      default: y_in = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete run; optionally pokes start and gate_sel while busy.
  task automatic run_one(input string name, input logic [2:0] gsel, input gate_t g,
                         input result_t exp, input bit disturb);
    bit         reserved;
    bit         seen;
    int         lat;
    logic [1:0] exp_ab;
    result_t    got;
    result_t    want;
    reserved = (gsel > 3'd4);
    lat      = reserved ? 0 : 4 * S;
    seen     = 1'b0;
    @(negedge clk);
    gate     = g;
    gate_sel = gsel;
    start    = 1'b1;
    sb.push_back(exp);
    for (int j = 0; j <= 4 * S + 4; j++) begin
      @(negedge clk);
      if (j == 0) start = 1'b0;
      exp_ab = (!reserved && j < 4 * S) ? 2'(j / S) : 2'd0;
      check({name, "_ab"}, {30'd0, a_out, b_out}, {30'd0, exp_ab});
      if (disturb && j == 3) begin
        start    = 1'b1;
        gate_sel = GSEL_XOR;
      end
      if (disturb && j == 4) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        check({name, "_latency"}, j, lat);
        check({name, "_busy_in_done"}, {31'd0, busy}, 32'd1);
        if (sb.size() == 0) begin
          check({name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          want = sb.pop_front();
          got  = {pass, err_count, err_vec};
          check({name, "_result"}, {24'd0, got}, {24'd0, want});
        end
        if (disturb) start = 1'b1;
        break;
      end
    end
    if (!seen) check({name, "_done_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    start = 1'b0;
    check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    result_t held;

    tbl[0] = '{"and_ok",    GSEL_AND,  G_AND, '{1'b1, 3'd0, 4'b0000}};
    tbl[1] = '{"or_ok",     GSEL_OR,   G_OR,  '{1'b1, 3'd0, 4'b0000}};
    tbl[2] = '{"xor_vs_or", GSEL_XOR,  G_OR,  '{1'b0, 3'd1, 4'b1000}};
    tbl[3] = '{"not_ok",    GSEL_NOT,  G_NOT, '{1'b1, 3'd0, 4'b0000}};
    tbl[4] = '{"not_st1",   GSEL_NOT,  G_ST1, '{1'b0, 3'd2, 4'b1100}};
    tbl[5] = '{"xnor_st0",  GSEL_XNOR, G_ST0, '{1'b0, 3'd2, 4'b1001}};
    tbl[6] = '{"reserved6", 3'd6,      G_AND, '{1'b0, 3'd4, 4'b1111}};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_outs", {25'd0, a_out, b_out, busy, done, pass, err_count == 3'd0, err_vec == 4'd0},
          {25'd0, 7'b0000011});
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      run_one(tbl[k].name, tbl[k].gsel, tbl[k].gate, tbl[k].exp, 1'b0);
      if (k == 5) begin
        held = tbl[k].exp;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("hold_result", {23'd0, done, pass, err_count, err_vec}, {23'd0, 1'b0, held});
        end
      end
    end

    // Start pulses during RUN and DONE plus a mid-run select change are ignored.
    run_one("and_disturbed", GSEL_AND, G_AND, '{1'b1, 3'd0, 4'b0000}, 1'b1);

    // Reset while vector 2 is on the pins aborts without a done pulse.
    @(negedge clk);
    gate     = G_AND;
    gate_sel = GSEL_AND;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ({a_out, b_out} == 2'd2) break;
      @(negedge clk);
    end
    check("reset_reach_vec2", {30'd0, a_out, b_out}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {25'd0, a_out, b_out, busy, done, pass, err_count, err_vec},
          {25'd0, 7'd0, 4'd0} >> 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("abort_quiet", {30'd0, busy, done}, 32'd0);
    end
    rst_n = 1'b1;
    run_one("and_after_reset", GSEL_AND, G_AND, '{1'b1, 3'd0, 4'b0000}, 1'b0);

    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time guard so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
